// File: rtl/ternary_op_scheduler.sv
// ---------------------------------------------------------------------------
// ternary_op_scheduler
//
// Purpose:
//   Shares one ternary ALU (min / max / any / consensus) between two
//   requesters. A round-robin arbiter picks a requester in IDLE. The operand
//   vectors are evaluated trit by trit (one trit per cycle), and the result
//   is returned over a valid/ready response channel.
//
//   Trit encoding: 00=0, 01=1, 10=2, 11=invalid.
//   Trit i occupies bits [2i+1:2i].
//
// Configuration macro:
//   TERNARY_SCHED_PARALLEL_EN - when defined, BUSY lasts a single cycle and
//   all N trits are evaluated in parallel. When undefined, the block is
//   serial and spends N cycles in BUSY. Results, error rules and handshakes
//   are the same in both builds.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   reqX_valid / reqX_ready requester X request handshake (X = 0, 1)
//   reqX_op                 00=min 01=max 10=any 11=consensus
//   reqX_a, reqX_b          operand vectors, 2*N bits each
//   rsp_valid / rsp_ready   response handshake
//   rsp_data                result vector
//   rsp_id                  index of the requester that issued the result
//   rsp_err                 at least one operand trit was 11
//   busy                    high while a job is in BUSY or DONE
// ---------------------------------------------------------------------------
module ternary_op_scheduler #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [1:0]     req0_op,
    input  logic [2*N-1:0] req0_a,
    input  logic [2*N-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [1:0]     req1_op,
    input  logic [2*N-1:0] req1_a,
    input  logic [2*N-1:0] req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_data,
    output logic           rsp_id,
    output logic           rsp_err,
    output logic           busy
);

    localparam int W = 2 * N;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Evaluate one trit pair; returns {err, result_trit}.
    function automatic logic [2:0] trit_eval(input logic [1:0] op,
                                             input logic [1:0] ta,
                                             input logic [1:0] tb);
        logic [1:0] r;
        logic [2:0] sum;
        logic       err;
        r   = 2'b00;
        err = 1'b0;
        sum = {1'b0, ta} + {1'b0, tb};
        if ((ta == 2'b11) || (tb == 2'b11)) begin
            err = 1'b1;
            r   = 2'b00;
        end else begin
            case (op)
                2'b00:   r = (ta < tb) ? ta : tb;
                2'b01:   r = (ta > tb) ? ta : tb;
                // any: a+b-1 clamped to [0,2]
                2'b10: begin
                    if (sum <= 3'd1) begin
                        r = 2'd0;
                    end else if (sum >= 3'd3) begin
                        r = 2'd2;
                    end else begin
                        r = 2'd1;
                    end
                end
                2'b11:   r = (ta == tb) ? ta : 2'd1;
                default: r = 2'b00;
            endcase
        end
        return {err, r};
    endfunction

    state_t         state_q;
    logic           rr_ptr_q;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic           err_q;
    logic [W-1:0]   res_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_id_q;
    logic           rsp_err_q;
    logic           busy_q;

`ifndef TERNARY_SCHED_PARALLEL_EN
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    logic [IDX_W-1:0] idx_q;
`endif

    logic           gnt_valid_s;
    logic           gnt_id_s;
    logic [1:0]     gnt_op_s;
    logic [W-1:0]   gnt_a_s;
    logic [W-1:0]   gnt_b_s;
    logic [W-1:0]   calc_res_s;
    logic           calc_err_s;

    // Grant selection in IDLE: single requester wins, ties go to rr_ptr.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = rr_ptr_q;
            end else if (req0_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_id_s    = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        gnt_op_s = 2'b00;
        gnt_a_s  = '0;
        gnt_b_s  = '0;
        if (gnt_id_s) begin
            gnt_op_s = req1_op;
            gnt_a_s  = req1_a;
            gnt_b_s  = req1_b;
        end else begin
            gnt_op_s = req0_op;
            gnt_a_s  = req0_a;
            gnt_b_s  = req0_b;
        end
    end

    assign req0_ready = gnt_valid_s & ~gnt_id_s;
    assign req1_ready = gnt_valid_s &  gnt_id_s;

    // Trit datapath: merges this cycle's trit(s) into the running result.
    always_comb begin
        logic [2:0] t_s;
        calc_res_s = res_q;
        calc_err_s = err_q;
        t_s        = 3'b000;
`ifdef TERNARY_SCHED_PARALLEL_EN
        for (int i = 0; i < N; i++) begin
            t_s = trit_eval(op_q, a_q[2*i +: 2], b_q[2*i +: 2]);
            calc_res_s[2*i +: 2] = t_s[1:0];
            calc_err_s           = calc_err_s | t_s[2];
        end
`else
        t_s = trit_eval(op_q, a_q[2*int'(idx_q) +: 2], b_q[2*int'(idx_q) +: 2]);
        calc_res_s[2*int'(idx_q) +: 2] = t_s[1:0];
        calc_err_s                     = err_q | t_s[2];
`endif
    end

    // Scheduler FSM with registered response and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifndef TERNARY_SCHED_PARALLEL_EN
            idx_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid_s) begin
                        op_q     <= gnt_op_s;
                        a_q      <= gnt_a_s;
                        b_q      <= gnt_b_s;
                        id_q     <= gnt_id_s;
                        rr_ptr_q <= ~gnt_id_s;
                        err_q    <= 1'b0;
                        res_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_BUSY;
`ifndef TERNARY_SCHED_PARALLEL_EN
                        idx_q    <= '0;
`endif
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    res_q <= calc_res_s;
                    err_q <= calc_err_s;
`ifdef TERNARY_SCHED_PARALLEL_EN
                    state_q     <= S_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= calc_res_s;
                    rsp_err_q   <= calc_err_s;
                    rsp_id_q    <= id_q;
`else
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= calc_res_s;
                        rsp_err_q   <= calc_err_s;
                        rsp_id_q    <= id_q;
                    end else begin
                        idx_q       <= idx_q + IDX_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    // Response fields hold their values after the handshake.
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ternary_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ternary_op_scheduler
//
// Self-checking bench for ternary_op_scheduler (N=4). Expected results come
// from a trit-level arithmetic model; arbitration is tracked with an integer
// round-robin pointer. Inputs are driven and outputs sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_ternary_op_scheduler;

    localparam int N = 4;
    localparam int W = 2 * N;
`ifdef TERNARY_SCHED_PARALLEL_EN
    localparam int LAT     = 2;
    localparam int RST_DLY = 1;
`else
    localparam int LAT     = N + 1;
    localparam int RST_DLY = 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    always #5 clk = ~clk;

    ternary_op_scheduler #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {err, data} computed trit by trit with integers.
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         e;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < N; i++) begin
            int ta, tb, r;
            ta = int'(a[2*i +: 2]);
            tb = int'(b[2*i +: 2]);
            if (ta == 3 || tb == 3) begin
                e = 1'b1;
                r = 0;
            end else begin
                case (op)
                    2'd0: r = (ta < tb) ? ta : tb;
                    2'd1: r = (ta > tb) ? ta : tb;
                    2'd2: begin
                        r = ta + tb - 1;
                        if (r < 0) r = 0;
                        if (r > 2) r = 2;
                    end
                    default: r = (ta == tb) ? ta : 1;
                endcase
            end
            d[2*i +: 2] = r[1:0];
        end
        return {e, d};
    endfunction

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        rr_m  = 0;
    endtask

    // One job from a single requester, with latency and response checks.
    task automatic one_job(input string tag, input int who, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_d, input logic exp_e);
        int c;
        @(negedge clk);
        rsp_ready  = 1'b1;
        req0_valid = (who == 0);
        req1_valid = (who == 1);
        req0_op = op; req0_a = a; req0_b = b;
        req1_op = op; req1_a = a; req1_b = b;
        #1;
        chk({tag, "_ready"}, 32'((who == 0) ? req0_ready : req1_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_m = 1 - who;
        c = 1;
        while (!rsp_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 32'(c), 32'(LAT));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, "_id"}, 32'(rsp_id), 32'(who));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_data_hold"}, 32'(rsp_data), 32'(exp_d));
    endtask

    initial begin : main
        logic [W:0]   m;
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        int           grants, g, who, seen, c;
        logic [1:0]   op;
        logic [W-1:0] a, b;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        // Reset values
        apply_reset(3);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);

        // Directed operations
        one_job("min", 0, 2'b00, 8'h92, 8'h58, 8'h50, 1'b0);
        one_job("max", 0, 2'b01, 8'h92, 8'h58, 8'h9A, 1'b0);
        one_job("any", 0, 2'b10, 8'h92, 8'h58, 8'h95, 1'b0);
        one_job("cons", 0, 2'b11, 8'h92, 8'h58, 8'h55, 1'b0);
        one_job("err", 1, 2'b00, 8'hC2, 8'h58, 8'h00, 1'b1);

        // Random single-requester jobs against the model
        for (int i = 0; i < 6; i++) begin
            who = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            a   = W'($urandom);
            b   = W'($urandom);
            m   = model(op, a, b);
            one_job("rand", who, op, a, b, m[W-1:0], m[W]);
        end

        // Both requesters held valid: grants must alternate from 0
        apply_reset(2);
        rsp_ready = 1'b1;
        grants = 0;
        c = 0;
        while ((grants < 6 || q.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
            if (grants < 6) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
                req0_a = W'($urandom); req0_b = W'($urandom);
                req1_a = W'($urandom); req1_b = W'($urandom);
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rr_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rr_rsp_id", 32'(rsp_id), 32'(e[W+1]));
                    chk("rr_rsp_err", 32'(rsp_err), 32'(e[W]));
                    chk("rr_rsp_data", 32'(rsp_data), 32'(e[W-1:0]));
                end
            end
            if (req0_ready || req1_ready) begin
                g = int'(req1_ready);
                chk("rr_grant", 32'(g), 32'(rr_m));
                chk("rr_single_ready", 32'(req0_ready & req1_ready), 32'd0);
                if (g == 1) m = model(req1_op, req1_a, req1_b);
                else        m = model(req0_op, req0_a, req0_b);
                q.push_back({g[0], m});
                rr_m = 1 - g;
                grants++;
            end
        end
        chk("rr_grant_count", 32'(grants), 32'd6);
        chk("rr_queue_empty", 32'(q.size()), 32'd0);

        // Back-pressure in DONE with a second request pending
        @(negedge clk);
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b01; req0_a = 8'h92; req0_b = 8'h58;
        req1_op = 2'b10; req1_a = 8'h92; req1_b = 8'h58;
        #1;
        g = rr_m;
        chk("stall_first_grant", 32'(req1_ready), 32'(g));
        m = (g == 1) ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
        rr_m = 1 - g;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rsp_valid && c < 40);
        chk("stall_latency", 32'(c), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(m[W-1:0]));
            chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_next_ready", 32'({req0_ready, req1_ready}), (rr_m == 1) ? 32'd1 : 32'd2);
        m = (rr_m == 1) ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
        g = rr_m;
        rr_m = 1 - g;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("stall_next_busy", 32'(busy), 32'd1);
        c = 1;
        while (!rsp_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("stall_next_data", 32'(rsp_data), 32'(m[W-1:0]));
        chk("stall_next_id", 32'(rsp_id), 32'(g));
        @(negedge clk);

        // Reset while BUSY: job aborted, pointer back to requester 0
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 2'b00; req0_a = 8'h92; req0_b = 8'h58;
        #1;
        chk("abort_accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (RST_DLY - 1) @(negedge clk);
        chk("abort_in_busy", 32'(busy & ~rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rr_m  = 0;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("abort_rr_ptr", 32'({req0_ready, req1_ready}), 32'd2);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
